// File: rtl/ec_pindex_reader_pkg.sv
// Shared types and width helpers for the pooling-index reader.
// The package is imported by the interface user, the FIFO and the top.
package bcedn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  function automatic int clog2_min1(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int pindex_width(
    input int ph,
    input int pw,
    input int npe
  );
    int w;
    w = $clog2(ph * pw) * npe;
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int addr_width(input int depth);
    return clog2_min1(depth);
  endfunction

endpackage

// File: rtl/ec_pindex_reader_if.sv
// SRAM read port plus the replayed index stream.
// master = reader side, slave = SRAM/consumer side.
interface ec_pindex_reader_if #(
  parameter int PINDEX_WIDTH = 4,
  parameter int ADDR_W       = 3
);

  logic                    pindex_rd;
  logic [ADDR_W-1:0]       pindex_rd_addr;
  logic [PINDEX_WIDTH-1:0] pindex_in;
  logic                    out_valid;
  logic                    out_ready;
  logic [PINDEX_WIDTH-1:0] out_pindex;
  logic                    out_eol;
  logic                    out_last;

  modport master (
    output pindex_rd,
    output pindex_rd_addr,
    input  pindex_in,
    output out_valid,
    input  out_ready,
    output out_pindex,
    output out_eol,
    output out_last
  );

  modport slave (
    input  pindex_rd,
    input  pindex_rd_addr,
    output pindex_in,
    input  out_valid,
    output out_ready,
    input  out_pindex,
    input  out_eol,
    input  out_last
  );

endinterface

// File: rtl/ec_pindex_reader_fifo.sv
// Two-entry skid FIFO that absorbs the one-cycle SRAM read latency.
// Clear drops all entries; head data comes straight from storage.
module pindex_skid_fifo
  import bcedn_pkg::*;
#(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clear,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_dout,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_mem [2];
  logic         r_wr;
  logic         r_rd;
  logic [1:0]   r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        r_mem[i] <= '0;
      end
      r_wr  <= 1'b0;
      r_rd  <= 1'b0;
      r_cnt <= 2'd0;
    end else if (i_clear) begin
      r_wr  <= 1'b0;
      r_rd  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_din;
        r_wr        <= ~r_wr;
      end
      if (i_pop) begin
        r_rd <= ~r_rd;
      end
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_dout  = r_mem[r_rd];
  assign o_count = r_cnt;

endmodule

// File: rtl/ec_pindex_reader.sv
// Replays pooling indices in raster order, each pooled row REP times,
// as a valid/ready stream fed from the index SRAM.
module ec_pindex_reader
  import bcedn_pkg::*;
#(
  parameter int H_OUT  = 16,
  parameter int W_OUT  = 64,
  parameter int FD     = 512,
  parameter int N_PE   = 1,
  parameter int POOL_H = 2,
  parameter int POOL_W = 2,
  parameter int REP    = POOL_H,
  localparam int GROUPS  = FD / N_PE,
  localparam int ROW_LEN = W_OUT * GROUPS,
  localparam int DEPTH   = H_OUT * ROW_LEN,
  localparam int ADDR_W  = addr_width(DEPTH),
  localparam int PINDEX_WIDTH =
    pindex_width(POOL_H, POOL_W, N_PE)
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic done,
  ec_pindex_reader_if.master bus
);

  localparam int OFF_W = clog2_min1(ROW_LEN);
  localparam int REP_W = clog2_min1(REP);
  localparam int ROW_W = clog2_min1(H_OUT);
  localparam int FW    = PINDEX_WIDTH + 2;

  state_t r_state;
  state_t w_next;

  logic [OFF_W-1:0]  r_off;
  logic [REP_W-1:0]  r_rep;
  logic [ROW_W-1:0]  r_row;
  logic [ADDR_W-1:0] r_base;

  logic r_inflight;
  logic r_inf_eol;
  logic r_inf_last;

  logic [1:0]    w_count;
  logic [2:0]    w_occ;
  logic [FW-1:0] w_head;
  logic          w_pop;
  logic          w_issue;
  logic          w_eol;
  logic          w_rep_last;
  logic          w_final;
  logic          w_done;
  logic          w_load;

  assign w_eol      = (r_off == OFF_W'(ROW_LEN - 1));
  assign w_rep_last = (r_rep == REP_W'(REP - 1));
  assign w_final    = w_eol && w_rep_last &&
                      (r_row == ROW_W'(H_OUT - 1));

  assign w_pop = bus.out_valid & bus.out_ready;

  // The word leaving this cycle frees its slot, so a
  // ready consumer sees one word per cycle.
  assign w_occ = {1'b0, w_count}
               + {2'b0, r_inflight}
               - {2'b0, w_pop};

  assign w_issue = (r_state == RUN) && (w_occ < 3'd2);
  assign w_load  = (r_state == IDLE) && start;

  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) w_next = RUN;
      end
      RUN: begin
        if (w_issue && w_final) w_next = DRAIN;
      end
      DRAIN: begin
        if (w_count == 2'd0 && !r_inflight) begin
          w_next = IDLE;
          w_done = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
    if (abort) begin
      w_next = IDLE;
      w_done = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst || abort || w_load) begin
      r_off  <= '0;
      r_rep  <= '0;
      r_row  <= '0;
      r_base <= '0;
    end else if (w_issue) begin
      if (w_eol) begin
        r_off <= '0;
        if (w_rep_last) begin
          r_rep  <= '0;
          r_row  <= r_row + ROW_W'(1);
          r_base <= r_base + ADDR_W'(ROW_LEN);
        end else begin
          r_rep <= r_rep + REP_W'(1);
        end
      end else begin
        r_off <= r_off + OFF_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      r_inflight <= 1'b0;
      r_inf_eol  <= 1'b0;
      r_inf_last <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      r_inf_eol  <= w_eol;
      r_inf_last <= w_final;
    end
  end

  pindex_skid_fifo #(
    .W(FW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_clear (abort),
    .i_push  (r_inflight),
    .i_pop   (w_pop),
    .i_din   ({bus.pindex_in, r_inf_eol, r_inf_last}),
    .o_dout  (w_head),
    .o_count (w_count)
  );

  assign bus.pindex_rd      = w_issue;
  assign bus.pindex_rd_addr = r_base + ADDR_W'(r_off);
  assign bus.out_valid      = (w_count != 2'd0);
  assign bus.out_pindex     = w_head[FW-1:2];
  assign bus.out_eol        = w_head[1];
  assign bus.out_last       = w_head[0];

  assign busy = (r_state != IDLE);
  assign done = w_done;

endmodule
